// File: rtl/vga_timing_pkg.sv
// Shared raster constants for 640x480@60 and the coordinate type that the
// renderer stages use for DrawX/DrawY.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/sig_delay.sv
// DEPTH-stage shift register of WIDTH-bit words; every stage loads RESET_VAL
// on reset. DEPTH=0 degenerates to a plain wire.
module sig_delay #(
    parameter int                DEPTH     = 2,
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_dout = i_din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered sync/blank/strobe
// decode, and sync/blank copies delayed to match the renderer pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic   vga_clk,
    input  logic   reset,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   hs_d,
    output logic   vs_d,
    output logic   blank_d,
    output logic   line_start,
    output logic   frame_start,
    output logic   frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_badWidth
            $error("vga_timing_gen: raster totals do not fit the coordinate width");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_badDelay
            $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
        end
    endgenerate

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
    localparam coord_t V_LAST_VIS = coord_t'(V_VISIBLE - 1);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    logic       r_run;
    coord_t     r_hc;
    coord_t     r_vc;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_lineStart;
    logic       r_frameStart;
    logic       r_frameEnd;
    coord_t     w_hcNext;
    coord_t     w_vcNext;
    logic [2:0] w_delayed;

    // r_run holds the counters at (0,0) for the first clock after reset, so
    // that pixel is presented with its strobes instead of being skipped.
    always_comb begin
        w_hcNext = '0;
        w_vcNext = '0;
        if (r_run) begin
            if (r_hc == H_LAST) begin
                w_hcNext = '0;
                w_vcNext = (r_vc == V_LAST) ? '0 : r_vc + coord_t'(1);
            end else begin
                w_hcNext = r_hc + coord_t'(1);
                w_vcNext = r_vc;
            end
        end
    end

    // Decoding the next position keeps every output aligned with DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_hc         <= '0;
            r_vc         <= '0;
            r_blank      <= 1'b0;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameEnd   <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_hc         <= w_hcNext;
            r_vc         <= w_vcNext;
            r_blank      <= (w_hcNext < H_VIS) && (w_vcNext < V_VIS);
            r_hs         <= !((w_hcNext >= HS_START) && (w_hcNext < HS_END));
            r_vs         <= !((w_vcNext >= VS_START) && (w_vcNext < VS_END));
            r_lineStart  <= (w_hcNext == '0);
            r_frameStart <= (w_hcNext == '0) && (w_vcNext == '0);
            r_frameEnd   <= (w_hcNext == H_VIS) && (w_vcNext == V_LAST_VIS);
        end
    end

    sig_delay #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     (3),
        .RESET_VAL (3'b110)
    ) u_syncDelay (
        .clk    (vga_clk),
        .reset  (reset),
        .i_din  ({r_hs, r_vs, r_blank}),
        .o_dout (w_delayed)
    );

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;
    assign frame_end   = r_frameEnd;
    assign hs_d        = w_delayed[2];
    assign vs_d        = w_delayed[1];
    assign blank_d     = w_delayed[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance plus two reduced-raster
// instances (PIPE_DELAY 2 and 0) so whole frames fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   blank;
        logic   hs;
        logic   vs;
        logic   hsD;
        logic   vsD;
        logic   blankD;
        logic   ls;
        logic   fs;
        logic   fe;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coord_t aX, aY, bX, bY, cX, cY;
    logic aBlank, aHs, aVs, aHsD, aVsD, aBlankD, aLs, aFs, aFe;
    logic bBlank, bHs, bVs, bHsD, bVsD, bBlankD, bLs, bFs, bFe;
    logic cBlank, cHs, cVs, cHsD, cVsD, cBlankD, cLs, cFs, cFe;

    vga_timing_gen #(.PIPE_DELAY(2)) dutA (
        .vga_clk(clk), .reset(reset), .DrawX(aX), .DrawY(aY),
        .blank(aBlank), .hs(aHs), .vs(aVs), .hs_d(aHsD), .vs_d(aVsD),
        .blank_d(aBlankD), .line_start(aLs), .frame_start(aFs), .frame_end(aFe)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
    ) dutB (
        .vga_clk(clk), .reset(reset), .DrawX(bX), .DrawY(bY),
        .blank(bBlank), .hs(bHs), .vs(bVs), .hs_d(bHsD), .vs_d(bVsD),
        .blank_d(bBlankD), .line_start(bLs), .frame_start(bFs), .frame_end(bFe)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0)
    ) dutC (
        .vga_clk(clk), .reset(reset), .DrawX(cX), .DrawY(cY),
        .blank(cBlank), .hs(cHs), .vs(cVs), .hs_d(cHsD), .vs_d(cVsD),
        .blank_d(cBlankD), .line_start(cLs), .frame_start(cFs), .frame_end(cFe)
    );

    obs_t obsA, obsB, obsC;
    assign obsA = {aX, aY, aBlank, aHs, aVs, aHsD, aVsD, aBlankD, aLs, aFs, aFe};
    assign obsB = {bX, bY, bBlank, bHs, bVs, bHsD, bVsD, bBlankD, bLs, bFs, bFe};
    assign obsC = {cX, cY, cBlank, cHs, cVs, cHsD, cVsD, cBlankD, cLs, cFs, cFe};

    int hVis[3]  = '{640, 16, 16};
    int hFp[3]   = '{16, 2, 2};
    int hSyn[3]  = '{96, 4, 4};
    int hBp[3]   = '{48, 3, 3};
    int vVis[3]  = '{480, 12, 12};
    int vFp[3]   = '{10, 2, 2};
    int vSyn[3]  = '{2, 2, 2};
    int vBp[3]   = '{33, 3, 3};
    int pipeD[3] = '{2, 2, 0};

    int       mX[3];
    int       mY[3];
    bit       mRun[3];
    logic [2:0] mHist[3][8];

    obs_t qA[$];
    obs_t qB[$];
    obs_t qC[$];

    int testCount = 0;
    int failCount = 0;

    int     aSinceLs, aHsLow;
    bit     aSeenLs;
    logic   aPrevBlank;
    int     bSinceFs, bVsLow, bFeCount;
    bit     bSeenFs;
    coord_t bPrevX, bPrevY;

    // Reference raster model: expected outputs after the next clock edge.
    task automatic modelStep(input int k, input logic rst, output obs_t e);
        int hTot, vTot;
        logic [2:0] u, d;
        hTot = hVis[k] + hFp[k] + hSyn[k] + hBp[k];
        vTot = vVis[k] + vFp[k] + vSyn[k] + vBp[k];
        e = '0;
        if (rst) begin
            mX[k] = 0;
            mY[k] = 0;
            mRun[k] = 1'b0;
            for (int i = 0; i < 8; i++) mHist[k][i] = 3'b110;
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            e.hsD = 1'b1; e.vsD = 1'b1; e.blankD = 1'b0;
        end else begin
            if (mRun[k]) begin
                mX[k]++;
                if (mX[k] == hTot) begin
                    mX[k] = 0;
                    mY[k]++;
                    if (mY[k] == vTot) mY[k] = 0;
                end
            end
            mRun[k] = 1'b1;
            e.x     = coord_t'(mX[k]);
            e.y     = coord_t'(mY[k]);
            e.blank = (mX[k] < hVis[k]) && (mY[k] < vVis[k]);
            e.hs    = !((mX[k] >= hVis[k] + hFp[k]) && (mX[k] < hVis[k] + hFp[k] + hSyn[k]));
            e.vs    = !((mY[k] >= vVis[k] + vFp[k]) && (mY[k] < vVis[k] + vFp[k] + vSyn[k]));
            e.ls    = (mX[k] == 0);
            e.fs    = (mX[k] == 0) && (mY[k] == 0);
            e.fe    = (mX[k] == hVis[k]) && (mY[k] == vVis[k] - 1);
            u = {e.hs, e.vs, e.blank};
            d = (pipeD[k] == 0) ? u : mHist[k][pipeD[k]-1];
            {e.hsD, e.vsD, e.blankD} = d;
            for (int i = 7; i > 0; i--) mHist[k][i] = mHist[k][i-1];
            mHist[k][0] = u;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input logic rst);
        obs_t e;
        e = qA.pop_front();
        check("dutA_state", 32'(obsA), 32'(e));
        e = qB.pop_front();
        check("dutB_state", 32'(obsB), 32'(e));
        e = qC.pop_front();
        check("dutC_state", 32'(obsC), 32'(e));
        check("dutC_passthrough", {29'd0, cHsD, cVsD, cBlankD}, {29'd0, cHs, cVs, cBlank});

        if (rst) begin
            aSeenLs = 1'b0; aPrevBlank = 1'b0;
            bSeenFs = 1'b0; bPrevX = '0; bPrevY = '0;
        end else begin
            // Line-level timing of the full-size raster.
            aSinceLs++;
            if (aLs) begin
                if (aSeenLs) begin
                    check("line_period", aSinceLs, 800);
                    check("hs_low_clocks", aHsLow, 96);
                end
                aSeenLs = 1'b1; aSinceLs = 0; aHsLow = 0;
            end
            if (!aHs) aHsLow++;
            if (aPrevBlank && !aBlank) check("blank_fall_x", 32'(aX), 640);
            aPrevBlank = aBlank;

            // Frame-level timing of the reduced raster (25 x 19).
            bSinceFs++;
            if (bFe) begin
                bFeCount++;
                check("frame_end_pos", {12'd0, bX, bY}, {12'd0, 10'd16, 10'd11});
            end
            if (bFs) begin
                if (bSeenFs) begin
                    check("frame_period", bSinceFs, 475);
                    check("vs_low_clocks", bVsLow, 50);
                    check("frame_end_count", bFeCount, 1);
                end
                bSeenFs = 1'b1; bSinceFs = 0; bVsLow = 0; bFeCount = 0;
            end
            if (!bVs) bVsLow++;
            if (bPrevX == 10'd24 && bPrevY == 10'd18)
                check("wrap_corner", {11'd0, bX, bY, bFs}, {11'd0, 10'd0, 10'd0, 1'b1});
            bPrevX = bX; bPrevY = bY;
        end
    endtask

    task automatic applyStimulus(input logic rst, input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = rst;
            modelStep(0, rst, e); qA.push_back(e);
            modelStep(1, rst, e); qB.push_back(e);
            modelStep(2, rst, e); qC.push_back(e);
            @(posedge clk);
            #1;
            checkOutput(rst);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 5);
        check("reset_coords", {12'd0, aX, aY}, 32'd0);
        check("reset_sync_blank", {29'd0, aHs, aVs, aBlank}, {29'd0, 3'b110});
        check("reset_strobes", {29'd0, aLs, aFs, aFe}, 32'd0);

        applyStimulus(1'b0, 1);
        check("release_strobes", {29'd0, aFs, aLs, aBlank}, {29'd0, 3'b111});

        applyStimulus(1'b0, 1600);

        for (int i = 0; i < 600; i++) begin
            if (mX[1] == 10 && mY[1] == 8) break;
            applyStimulus(1'b0, 1);
        end
        check("reach_mid_frame", {12'd0, bX, bY}, {12'd0, 10'd10, 10'd8});

        applyStimulus(1'b1, 1);
        check("midreset_coords", {12'd0, bX, bY}, 32'd0);
        check("midreset_delay_stages", {29'd0, bHsD, bVsD, bBlankD}, {29'd0, 3'b110});
        check("midreset_strobes", {29'd0, bLs, bFs, bFe}, 32'd0);

        applyStimulus(1'b0, 1);
        check("resume_frame_start", {30'd0, bFs, aFs}, {30'd0, 2'b11});

        applyStimulus(1'b0, 1000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
